// File: rtl/lcd_status_reader.sv
`timescale 1ns/1ps
// lcd_status_reader: read-side controller for an HD44780-style character LCD.
// Runs RW=1 bus cycles (status or DDRAM data), optionally repeating status
// reads until the busy flag clears, and returns the byte on a valid/ready
// handshake. Define LCD_READ_4BIT_EN to read over the upper nibble only
// (two E pulses per byte); the default build reads all 8 bits in one pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | bus released, waiting for a request
//   SETUP  | RS/RW driven, E low (address setup)
//   E_HIGH | E high; data bus sampled on the last cycle
//   E_LOW  | E low again, RS/RW held (hold time + cycle time)
//   CHECK  | one cycle: count the read, decide on another poll or respond
//   RESP   | bus released, response held until the consumer accepts it
module lcd_status_reader #(
  parameter int DATA_BITS     = 8,
  parameter int SETUP_CYCLES  = 4,
  parameter int E_HIGH_CYCLES = 25,
  parameter int E_LOW_CYCLES  = 25,
  parameter int MAX_POLLS     = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_kind,
  input  logic                 req_wait_idle,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_busy,
  output logic [6:0]           rsp_addr,
  output logic                 rsp_timeout,
  output logic                 bus_own,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  input  logic [DATA_BITS-1:0] lcd_db_i
);

  localparam int MAX_A     = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int MAX_PHASE = (MAX_A > E_LOW_CYCLES) ? MAX_A : E_LOW_CYCLES;
  localparam int TW        = $clog2(MAX_PHASE) + 1;
  localparam int PW        = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    E_HIGH = 3'd2,
    E_LOW  = 3'd3,
    CHECK  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t               state_q, state_nxt;
  logic [TW-1:0]        timer_q, timer_nxt;
  logic [PW-1:0]        poll_q, poll_nxt, poll_inc;
  logic                 kind_q, kind_nxt;
  logic                 wait_q, wait_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 timeout_q, timeout_nxt;
  logic                 valid_q, valid_nxt;
  logic                 own_q, own_nxt;
  logic                 rs_q, rs_nxt;
  logic                 rw_q, rw_nxt;
  logic                 e_q, e_nxt;
`ifdef LCD_READ_4BIT_EN
  logic                 nib_q, nib_nxt;
  logic                 unused_db_lo;

  // Low nibble of the bus is not wired in 4-bit mode.
  assign unused_db_lo = ^lcd_db_i[3:0];
`endif

  // Poll count after this read, saturating at the limit.
  assign poll_inc = (poll_q == PW'(MAX_POLLS)) ? poll_q : poll_q + 1'b1;

  // Next-state and next-output logic; every bus pin is registered.
  always_comb begin
    state_nxt   = state_q;
    timer_nxt   = timer_q;
    poll_nxt    = poll_q;
    kind_nxt    = kind_q;
    wait_nxt    = wait_q;
    data_nxt    = data_q;
    timeout_nxt = timeout_q;
    valid_nxt   = valid_q;
    own_nxt     = own_q;
    rs_nxt      = rs_q;
    rw_nxt      = rw_q;
    e_nxt       = e_q;
`ifdef LCD_READ_4BIT_EN
    nib_nxt     = nib_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          kind_nxt  = req_kind;
          wait_nxt  = req_wait_idle & ~req_kind;
          rs_nxt    = req_kind;
          rw_nxt    = 1'b1;
          own_nxt   = 1'b1;
          poll_nxt  = '0;
          timer_nxt = TW'(SETUP_CYCLES - 1);
          state_nxt = SETUP;
`ifdef LCD_READ_4BIT_EN
          nib_nxt   = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (timer_q == '0) begin
          e_nxt     = 1'b1;
          timer_nxt = TW'(E_HIGH_CYCLES - 1);
          state_nxt = E_HIGH;
        end else begin
          timer_nxt = timer_q - 1'b1;
        end
      end
      E_HIGH: begin
        if (timer_q == '0) begin
`ifdef LCD_READ_4BIT_EN
          if (!nib_q) data_nxt[7:4] = lcd_db_i[7:4];
          else        data_nxt[3:0] = lcd_db_i[7:4];
`else
          data_nxt  = lcd_db_i;
`endif
          e_nxt     = 1'b0;
          timer_nxt = TW'(E_LOW_CYCLES - 1);
          state_nxt = E_LOW;
        end else begin
          timer_nxt = timer_q - 1'b1;
        end
      end
      E_LOW: begin
        if (timer_q == '0) begin
`ifdef LCD_READ_4BIT_EN
          if (!nib_q) begin
            nib_nxt   = 1'b1;
            timer_nxt = TW'(SETUP_CYCLES - 1);
            state_nxt = SETUP;
          end else begin
            nib_nxt   = 1'b0;
            state_nxt = CHECK;
          end
`else
          state_nxt = CHECK;
`endif
        end else begin
          timer_nxt = timer_q - 1'b1;
        end
      end
      CHECK: begin
        poll_nxt = poll_inc;
        if (wait_q && data_q[7] && (poll_inc < PW'(MAX_POLLS))) begin
          timer_nxt = TW'(SETUP_CYCLES - 1);
          state_nxt = SETUP;
        end else begin
          // Reaching here with BF still set while polling means the limit hit.
          timeout_nxt = wait_q & data_q[7];
          valid_nxt   = 1'b1;
          own_nxt     = 1'b0;
          rs_nxt      = 1'b0;
          rw_nxt      = 1'b0;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      poll_q    <= '0;
      kind_q    <= 1'b0;
      wait_q    <= 1'b0;
      data_q    <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      own_q     <= 1'b0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      e_q       <= 1'b0;
`ifdef LCD_READ_4BIT_EN
      nib_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      timer_q   <= timer_nxt;
      poll_q    <= poll_nxt;
      kind_q    <= kind_nxt;
      wait_q    <= wait_nxt;
      data_q    <= data_nxt;
      timeout_q <= timeout_nxt;
      valid_q   <= valid_nxt;
      own_q     <= own_nxt;
      rs_q      <= rs_nxt;
      rw_q      <= rw_nxt;
      e_q       <= e_nxt;
`ifdef LCD_READ_4BIT_EN
      nib_q     <= nib_nxt;
`endif
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = valid_q;
  assign rsp_data    = data_q;
  assign rsp_busy    = kind_q ? 1'b0 : data_q[7];
  assign rsp_addr    = kind_q ? 7'd0 : data_q[6:0];
  assign rsp_timeout = timeout_q;
  assign bus_own     = own_q;
  assign lcd_rs      = rs_q;
  assign lcd_rw      = rw_q;
  assign lcd_e       = e_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
`timescale 1ns/1ps
// Bench for lcd_status_reader: directed and random reads against a
// byte-sequence model of the LCD and the expected poll/response outcome.
// Honours LCD_READ_4BIT_EN (two nibble pulses per byte).
module tb_lcd_status_reader;

  localparam int S    = 4;
  localparam int H    = 25;
  localparam int L    = 25;
  localparam int MAXP = 5;
`ifdef LCD_READ_4BIT_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_kind, req_wait_idle;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_busy;
  logic [6:0] rsp_addr;
  logic       rsp_timeout, bus_own, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db_i;

  int tests = 0;
  int fails = 0;
  logic [7:0] bytes[$];

  always #5 clk = ~clk;

  lcd_status_reader #(
    .DATA_BITS(8), .SETUP_CYCLES(S), .E_HIGH_CYCLES(H),
    .E_LOW_CYCLES(L), .MAX_POLLS(MAXP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_wait_idle(req_wait_idle),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_busy(rsp_busy), .rsp_addr(rsp_addr),
    .rsp_timeout(rsp_timeout), .bus_own(bus_own),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db_i(lcd_db_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; the LCD answers each E pulse with the next entry derived from 'bytes'.
  task automatic run_read(input logic kind, input logic wait_i, input int hold);
    logic       weff;
    logic [7:0] b;
    logic [7:0] ent[$];
    int reads, exp_lat, edges, pulses, width, bad_width, bad_bus, unstable;
    logic prev_e, done;
    weff  = wait_i & ~kind;
    reads = 0;
    b     = 8'h00;
    for (int i = 0; i < bytes.size(); i++) begin
      b = bytes[i];
      reads++;
      if (!(weff && b[7] && reads < MAXP)) break;
    end
    for (int i = 0; i < bytes.size(); i++) begin
      if (NP == 1) ent.push_back(bytes[i]);
      else begin
        ent.push_back({bytes[i][7:4], 4'($urandom)});
        ent.push_back({bytes[i][3:0], 4'($urandom)});
      end
    end
    exp_lat = 1 + reads * (NP * (S + H + L) + 1);

    @(negedge clk);
    req_valid = 1'b1; req_kind = kind; req_wait_idle = wait_i;
    rsp_ready = (hold == 0);
    edges = 0; pulses = 0; width = 0; bad_width = 0; bad_bus = 0;
    prev_e = 1'b0; done = 1'b0;
    while (!done && edges < 3000) begin
      @(posedge clk); edges++;
      @(negedge clk);
      req_valid = 1'($urandom); req_kind = 1'($urandom); req_wait_idle = 1'($urandom);
      if (lcd_e && !prev_e) begin
        pulses++;
        lcd_db_i = (pulses <= ent.size()) ? ent[pulses-1] : 8'($urandom);
        width = 1;
      end else if (lcd_e) width++;
      else if (prev_e && width != H) bad_width++;
      prev_e = lcd_e;
      if (rsp_valid) begin
        done = 1'b1;
        req_valid = 1'b0;
      end else if (!(bus_own && lcd_rw && lcd_rs == kind && !req_ready)) bad_bus++;
    end
    req_valid = 1'b0;
    if (!done) chk("rsp_never_valid", 0, 1);
    else begin
      chk("latency", edges, exp_lat);
      chk("e_pulses", pulses, reads * NP);
      chk("e_width_bad", bad_width, 0);
      chk("bus_during_read_bad", bad_bus, 0);
      chk("rsp_data", rsp_data, b);
      chk("rsp_busy", rsp_busy, kind ? 1'b0 : b[7]);
      chk("rsp_addr", rsp_addr, kind ? 7'd0 : b[6:0]);
      chk("rsp_timeout", rsp_timeout, weff & b[7]);
      chk("released", {bus_own, lcd_rw, lcd_rs, lcd_e, req_ready}, 5'b0);
      unstable = 0;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); @(negedge clk);
        if (!(rsp_valid && !req_ready && !bus_own && rsp_data == b &&
              rsp_timeout == (weff & b[7]))) unstable++;
      end
      chk("hold_unstable", unstable, 0);
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      chk("after_hs_valid", rsp_valid, 1'b0);
      chk("after_hs_ready", req_ready, 1'b1);
    end
  endtask

  initial begin
    int nb, to;
    reset = 1'b0; req_valid = 1'b0; req_kind = 1'b0; req_wait_idle = 1'b0;
    rsp_ready = 1'b0; lcd_db_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp", {rsp_data, rsp_busy, rsp_addr, rsp_timeout}, 17'h0);
    chk("rst_bus", {bus_own, lcd_rs, lcd_rw, lcd_e}, 4'h0);
    reset = 1'b1;

    bytes = '{8'h05};                             run_read(1'b0, 1'b0, 0);
    bytes = '{8'h80, 8'h80, 8'h80, 8'h12};        run_read(1'b0, 1'b1, 1);
    bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
                                                  run_read(1'b0, 1'b1, 2);
    bytes = '{8'h41};                             run_read(1'b1, 1'b0, 10);
    bytes = '{8'hC1, 8'h00};                      run_read(1'b1, 1'b1, 0);
    bytes = '{8'h83};                             run_read(1'b0, 1'b0, 1);

    // Reset while E is high aborts the read at once.
    @(negedge clk);
    req_valid = 1'b1; req_kind = 1'b0; req_wait_idle = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    to = 0;
    while (!lcd_e && to < 100) begin
      @(posedge clk); @(negedge clk); to++;
    end
    chk("abort_saw_e", lcd_e, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1; rsp_ready = 1'b0;
    chk("abort_e", lcd_e, 1'b0);
    chk("abort_own", bus_own, 1'b0);
    chk("abort_valid", rsp_valid, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_no_rsp", rsp_valid, 1'b0);
    bytes = '{8'h2A};                             run_read(1'b0, 1'b0, 0);

    for (int t = 0; t < 12; t++) begin
      bytes.delete();
      nb = $urandom_range(0, 6);
      for (int i = 0; i < nb; i++) bytes.push_back({1'b1, 7'($urandom)});
      bytes.push_back({1'b0, 7'($urandom)});
      run_read(1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
